// File: rtl/m_divider.sv
`default_nettype none
// ============================================================================
//  Module   : m_divider
//  Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//             Sits in EX beside the multiplier, holds busy_o while working and
//             returns the result with a one-cycle done_o pulse.
//  Ports    : clk          clock, rising edge
//             rst          asynchronous active-high reset
//             start_i      request, sampled only while idle
//             flush_i      abort the in-flight operation
//             rs1_data_i   dividend
//             rs2_data_i   divisor
//             funct3_i     100 div, 101 divu, 110 rem, 111 remu (others = divu)
//             busy_o       high whenever the unit is not idle
//             done_o       one-cycle pulse, div_out_o valid in that cycle
//             div_out_o    quotient or remainder, held until the next result
//  Revision : 1.0  initial release
// ============================================================================
module m_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] rs1_data_i,
   input  logic [WIDTH-1:0] rs2_data_i,
   input  logic [2:0]       funct3_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] div_out_o
);

   localparam int         CW        = $clog2(WIDTH + 1);
   localparam logic [2:0] c_F3_DIV  = 3'b100;
   localparam logic [2:0] c_F3_REM  = 3'b110;
   localparam logic [2:0] c_F3_REMU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder R
   logic [WIDTH-1:0] quo_q, quo_d;       // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvsr_q, dvsr_d;     // divisor magnitude
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             sel_rem_q, sel_rem_d;
   logic [WIDTH-1:0] div_out_q, div_out_d;

   // Operand decode, only meaningful in the start cycle
   logic             w_signed, w_is_rem, w_a_neg, w_b_neg, w_div0, w_ovf;
   logic [WIDTH-1:0] w_a_abs, w_b_abs, w_special;
   logic [WIDTH:0]   w_trial;

   assign w_signed = (funct3_i == c_F3_DIV) || (funct3_i == c_F3_REM);
   assign w_is_rem = (funct3_i == c_F3_REM) || (funct3_i == c_F3_REMU);
   assign w_a_neg  = w_signed & rs1_data_i[WIDTH-1];
   assign w_b_neg  = w_signed & rs2_data_i[WIDTH-1];
   // |0x8000_0000| stays 0x8000_0000, which is correct read as unsigned
   assign w_a_abs  = w_a_neg ? -rs1_data_i : rs1_data_i;
   assign w_b_abs  = w_b_neg ? -rs2_data_i : rs2_data_i;
   assign w_div0   = (rs2_data_i == '0);
   assign w_ovf    = w_signed && (rs1_data_i == {1'b1, {(WIDTH-1){1'b0}}})
                              && (rs2_data_i == '1);

   always_comb begin
      w_special = '0;
      if (w_div0) begin
         w_special = w_is_rem ? rs1_data_i : '1;
      end else if (w_ovf) begin
         w_special = w_is_rem ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
      end
   end

   // Shift the next dividend bit into R and try to subtract; the extra MSB
   // of the shifted value is why the trial is WIDTH+1 bits wide.
   assign w_trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         sel_rem_q <= 1'b0;
         div_out_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         sel_rem_q <= sel_rem_d;
         div_out_q <= div_out_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      sel_rem_d = sel_rem_q;
      div_out_d = div_out_q;

      case (state_q)
         S_IDLE: begin
            // flush wins over a start arriving in the same cycle
            if (start_i && !flush_i) begin
               sel_rem_d = w_is_rem;
               neg_quo_d = w_a_neg ^ w_b_neg;
               neg_rem_d = w_a_neg;
               dvsr_d    = w_b_abs;
               quo_d     = w_a_abs;
               rem_d     = '0;
               cnt_d     = '0;
               if (w_div0 || w_ovf) begin
                  div_out_d = w_special;
                  state_d   = S_DONE;
               end else begin
                  state_d   = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               if (!w_trial[WIDTH]) begin
                  rem_d = w_trial[WIDTH-1:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  // restore: a failed trial implies the shifted R fits WIDTH bits
                  rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               if (sel_rem_q) begin
                  div_out_d = neg_rem_q ? -rem_q : rem_q;
               end else begin
                  div_out_d = neg_quo_q ? -quo_q : quo_q;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = (state_q == S_DONE) && !flush_i;
   assign div_out_o = div_out_q;

endmodule
`default_nettype wire

// File: tb/tb_m_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_divider
//  Purpose  : Scoreboard bench for m_divider. Stimulus pushes the expected
//             result and latency from an arithmetic reference model; a monitor
//             pops and compares on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_divider;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst;
   logic             start_i;
   logic             flush_i;
   logic [WIDTH-1:0] rs1_data_i;
   logic [WIDTH-1:0] rs2_data_i;
   logic [2:0]       funct3_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] div_out_o;

   m_divider #(.WIDTH(WIDTH)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .flush_i    (flush_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .funct3_i   (funct3_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .div_out_o  (div_out_o)
   );

   typedef struct {
      logic [31:0] val;
      int          lat;
      int          cyc;
      string       name;
   } exp_t;

   exp_t scb[$];
   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: RISC-V M-extension semantics in plain arithmetic
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      bit sgn = (f == 3'b100) || (f == 3'b110);
      bit rem = (f == 3'b110) || (f == 3'b111);
      int sa  = a;
      int sbv = b;
      if (b == 0) return rem ? a : 32'hFFFF_FFFF;
      if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
         return rem ? 32'(sa % sbv) : 32'(sa / sbv);
      end
      return rem ? a % b : a / b;
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
      bit sgn = (f == 3'b100) || (f == 3'b110);
      if (b == 0) return 1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return WIDTH + 2;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done_o) begin
         done_cnt++;
         if (scb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with div_out %h, required no done", div_out_o);
         end else begin
            exp_t e;
            e = scb.pop_front();
            chk({e.name, "_val"}, div_out_o, e.val);
            chk({e.name, "_lat"}, 32'(cyc - e.cyc), 32'(e.lat));
         end
      end
   end

   task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input string name);
      exp_t e;
      @(negedge clk);
      start_i    = 1'b1;
      funct3_i   = f;
      rs1_data_i = a;
      rs2_data_i = b;
      if (push) begin
         e.val  = model(f, a, b);
         e.lat  = model_lat(f, a, b);
         e.cyc  = cyc;
         e.name = name;
         scb.push_back(e);
      end
      @(negedge clk);
      // operands only need to be valid in the start cycle
      start_i    = 1'b0;
      funct3_i   = 3'($urandom);
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
   endtask

   task automatic wait_done(input string name);
      #1;
      for (int i = 0; i < 100; i++) begin
         if (scb.size() == 0) return;
         @(negedge clk);
         #1;
      end
      if (scb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d results pending, required 0", name, scb.size());
         scb.delete();
      end
   endtask

   task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input string name);
      launch(f, a, b, 1'b1, name);
      wait_done(name);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int saved_done;
      rst        = 1'b1;
      start_i    = 1'b0;
      flush_i    = 1'b0;
      funct3_i   = 3'b000;
      rs1_data_i = '0;
      rs2_data_i = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_done", 32'(done_o), 32'd0);
      chk("reset_out",  div_out_o,   32'd0);
      rst = 1'b0;

      op(3'b101, 32'd100, 32'd7, "divu_100_7");
      op(3'b111, 32'd100, 32'd7, "remu_100_7");
      op(3'b100, -32'sd7, 32'd2, "div_m7_2");
      op(3'b110, -32'sd7, 32'd2, "rem_m7_2");
      op(3'b110, 32'd7, -32'sd2, "rem_7_m2");
      op(3'b100, 32'd5, 32'd0, "div_5_0");
      op(3'b110, 32'd5, 32'd0, "rem_5_0");
      op(3'b101, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
      op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      op(3'b000, 32'd50, 32'd6, "f3_other_as_divu");

      // second start ten cycles into an op must be ignored
      launch(3'b101, 32'd1000, 32'd3, 1'b1, "divu_ignore_start");
      repeat (9) @(negedge clk);
      start_i    = 1'b1;
      funct3_i   = 3'b100;
      rs1_data_i = 32'd5;
      rs2_data_i = 32'd0;
      @(negedge clk);
      start_i    = 1'b0;
      wait_done("divu_ignore_start");

      // flush twenty cycles in: busy drops, no done, output kept
      saved_done = done_cnt;
      launch(3'b101, 32'd777, 32'd5, 1'b0, "flushed");
      repeat (19) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_busy", 32'(busy_o), 32'd0);
      repeat (40) @(negedge clk);
      chk("flush_no_done", 32'(done_cnt), 32'(saved_done));
      chk("flush_out_kept", div_out_o, 32'd333);

      // asynchronous reset mid-calculation
      launch(3'b100, -32'sd1234, 32'd7, 1'b0, "reset_mid");
      repeat (14) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy_o), 32'd0);
      chk("async_rst_done", 32'(done_o), 32'd0);
      chk("async_rst_out",  div_out_o,   32'd0);
      @(negedge clk);
      rst = 1'b0;

      op(3'b111, 32'd1234, 32'd100, "remu_after_rst");

      for (int i = 0; i < 60; i++) begin
         op(3'($urandom_range(0, 7)), pick(), pick(), $sformatf("rand%0d", i));
      end

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
